regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers, power of two, 2..64; AW = log2(NREGS).
REQ-003 Parameter NRP, default 2: number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: 1 hardwires register 0 to zero; 0 makes it a normal register.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 rd_en  in  1  read request; samples all read addresses this cycle.
REQ-008 rs_addr  in  NRP*AW  packed read addresses; port p uses bits [p*AW +: AW].
REQ-009 rd_data  out  NRP*XLEN  packed registered read data; port p uses bits [p*XLEN +: XLEN].
REQ-010 rd_busy  out  NRP  registered per-port flag: addressed register had a pending write when sampled.
REQ-011 rd_valid  out  1  pulses high one cycle after an accepted rd_en.
REQ-012 wr_en  in  1  write request.
REQ-013 wr_addr  in  AW  write destination.
REQ-014 wr_data  in  XLEN  write data.
REQ-015 alloc_en  in  1  marks a destination register as pending (producer issued).
REQ-016 alloc_addr  in  AW  register to mark pending.
REQ-017 busy_vec  out  NREGS  current scoreboard, one bit per register, driven directly from state.

Function
REQ-018 Read latency is exactly 1 cycle: rd_en at edge N gives rd_data, rd_busy and rd_valid=1 after edge N+1.
REQ-019 When rd_en=0, rd_data and rd_busy hold their previous values and rd_valid is 0 on the next cycle.
REQ-020 Reads and writes are independent and may occur in the same cycle; neither blocks the other.
REQ-021 Write-first bypass: if wr_en=1 and wr_addr equals rs_addr[p] in a cycle with rd_en=1, rd_data[p] returns wr_data, not the old value.
REQ-022 A write updates the register array on the edge where wr_en=1, except register 0 when ZERO_REG=1.
REQ-023 With ZERO_REG=1, a read of register 0 returns 0 and rd_busy 0, and this overrides the bypass.
REQ-024 Scoreboard: alloc_en=1 sets busy_vec[alloc_addr]; wr_en=1 clears busy_vec[wr_addr].
REQ-025 Simultaneous alloc_en and wr_en to the same register: the set wins and the bit ends at 1, because the new producer supersedes the old one.
REQ-026 Simultaneous alloc_en and wr_en to different registers: both updates apply.
REQ-027 With ZERO_REG=1, busy_vec[0] is constant 0 and alloc to register 0 is ignored.
REQ-028 rd_busy[p] reflects the scoreboard after the same-cycle write clear but before the same-cycle alloc set.
REQ-029 Alloc of an already-busy register leaves it busy; a write to a non-busy register is legal and leaves it clear.
REQ-030 Out-of-range addresses cannot occur because NREGS is a power of two; no range checking is required.
REQ-031 Multiple read ports may address the same register and each returns identical data.

Reset
REQ-032 While rst=0, asynchronously clear all registers to 0, busy_vec to 0, rd_data to 0, rd_busy to 0 and rd_valid to 0.
REQ-033 Reset asserted mid-operation discards any in-flight read result, and rd_valid is 0 on the first cycle after release.
REQ-034 wr_en, alloc_en and rd_en present on the first rising edge after rst deasserts are accepted normally.

Verification
REQ-035 Reset, then read registers 5 and 9 -> rd_data = 0/0, rd_busy = 0/0, rd_valid = 1 one cycle after rd_en.
REQ-036 Write 0xDEADBEEF to register 7 and read port 0 = register 7 in the same cycle -> rd_data[0] = 0xDEADBEEF (bypass); a read two cycles later returns the same value.
REQ-037 Write 0x1234 to register 0 with ZERO_REG=1, then read it -> 0 with rd_busy = 0; with ZERO_REG=0 -> 0x1234.
REQ-038 Alloc register 3, then read it -> rd_busy = 1 and busy_vec[3] = 1; then wr_en to register 3 together with alloc_en to register 3 -> busy_vec[3] stays 1; then write only -> busy_vec[3] = 0.
REQ-039 Alloc register 4, then issue a read of register 4 together with a write of 0x55 to it -> rd_data = 0x55 and rd_busy = 0.
REQ-040 Assert rst=0 asynchronously, mid-clock, while rd_en=1 and register 2 holds 0xFF -> outputs and busy_vec are 0 immediately; after release, reading register 2 returns 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-port register file with write-first bypass and a per-register
//            pending-write scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic [NRP*XLEN-1:0] rd_data_q;
    logic [NRP*XLEN-1:0] rd_data_d;
    logic [NRP-1:0]      rd_busy_q;
    logic [NRP-1:0]      rd_busy_d;
    logic                rd_valid_q;
    logic                w_wr_ok;
    logic [AW-1:0]       w_ra;
    logic                w_zero;
    logic                w_hit;

    assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Bypass and busy view both see this cycle's write; register 0 overrides both.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        w_ra      = '0;
        w_zero    = 1'b0;
        w_hit     = 1'b0;
        if (rd_en) begin
            for (int p = 0; p < NRP; p++) begin
                w_ra   = rs_addr[p*AW +: AW];
                w_zero = (ZERO_REG != 0) && (w_ra == '0);
                w_hit  = wr_en && (wr_addr == w_ra);
                if (w_zero) begin
                    rd_data_d[p*XLEN +: XLEN] = '0;
                    rd_busy_d[p]              = 1'b0;
                end else if (w_hit) begin
                    rd_data_d[p*XLEN +: XLEN] = wr_data;
                    rd_busy_d[p]              = 1'b0;
                end else begin
                    rd_data_d[p*XLEN +: XLEN] = regs_q[w_ra];
                    rd_busy_d[p]              = busy_q[w_ra];
                end
            end
        end
    end

    // Clear first, then set: a newly issued producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign rd_valid = rd_valid_q;
    assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed self-checking bench; a ZERO_REG=0 twin covers register 0.
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                rd_en;
    logic [NRP*AW-1:0]   rs_addr;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;

    logic [NRP*XLEN-1:0] rd_data,  rd_data_nz;
    logic [NRP-1:0]      rd_busy,  rd_busy_nz;
    logic                rd_valid, rd_valid_nz;
    logic [NREGS-1:0]    busy_vec, busy_vec_nz;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs_addr(rs_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs_addr(rs_addr),
        .rd_data(rd_data_nz), .rd_busy(rd_busy_nz), .rd_valid(rd_valid_nz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_nz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; alloc_en = 1'b0;
        rs_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en = 1'b1; rs_addr = {a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic al(input logic [AW-1:0] a);
        alloc_en = 1'b1; alloc_addr = a;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #12;
        check("reset_rd_data",  64'(rd_data),  64'h0);
        check("reset_rd_busy",  64'(rd_busy),  64'h0);
        check("reset_rd_valid", 64'(rd_valid), 64'h0);
        check("reset_busy_vec", 64'(busy_vec), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Read regs 5 and 9 after reset
        rd(5'd5, 5'd9); step(); idle();
        check("rd_5_9_data",  64'(rd_data),  64'h0);
        check("rd_5_9_busy",  64'(rd_busy),  64'h0);
        check("rd_5_9_valid", 64'(rd_valid), 64'h1);

        step();
        check("idle_valid", 64'(rd_valid), 64'h0);

        // Bypass on both ports to the same register
        wr(5'd7, 32'hDEADBEEF); rd(5'd7, 5'd7); step(); idle();
        check("bypass_r7_dual", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);
        check("bypass_valid",   64'(rd_valid), 64'h1);

        step();
        check("hold_data",  64'(rd_data),  64'hDEADBEEF_DEADBEEF);
        check("hold_valid", 64'(rd_valid), 64'h0);

        rd(5'd7, 5'd5); step(); idle();
        check("reread_r7", 64'(rd_data), 64'h00000000_DEADBEEF);

        // Register 0: hardwired vs normal
        wr(5'd0, 32'h1234); al(5'd0); step(); idle();
        check("zero_busy_vec",    64'(busy_vec),    64'h0);
        check("nz_r0_busy_vec",   64'(busy_vec_nz), 64'h1);

        rd(5'd0, 5'd7); step(); idle();
        check("zero_r0_data",  64'(rd_data),    64'hDEADBEEF_00000000);
        check("zero_r0_busy",  64'(rd_busy),    64'h0);
        check("nz_r0_data",    64'(rd_data_nz), 64'hDEADBEEF_00001234);
        check("nz_r0_busy",    64'(rd_busy_nz), 64'h1);

        wr(5'd0, 32'h99); rd(5'd0, 5'd0); step(); idle();
        check("zero_bypass_r0", 64'(rd_data),     64'h0);
        check("nz_bypass_r0",   64'(rd_data_nz),  64'h00000099_00000099);
        check("nz_bypass_busy", 64'(rd_busy_nz),  64'h0);
        check("nz_clear_r0",    64'(busy_vec_nz), 64'h0);

        // Scoreboard on register 3
        al(5'd3); step(); idle();
        check("alloc3_vec", 64'(busy_vec), 64'h8);
        rd(5'd3, 5'd5); step(); idle();
        check("alloc3_rd_busy", 64'(rd_busy), 64'h1);
        check("alloc3_rd_data", 64'(rd_data), 64'h0);
        wr(5'd3, 32'hA); al(5'd3); step(); idle();
        check("set_wins_vec", 64'(busy_vec), 64'h8);
        wr(5'd3, 32'hB); step(); idle();
        check("write_clears_vec", 64'(busy_vec), 64'h0);

        // Busy bypass on register 4 while allocating a different register
        al(5'd4); step(); idle();
        check("alloc4_vec", 64'(busy_vec), 64'h10);
        rd(5'd4, 5'd6); wr(5'd4, 32'h55); al(5'd6); step(); idle();
        check("bypass4_data", 64'(rd_data),  64'h00000000_00000055);
        check("bypass4_busy", 64'(rd_busy),  64'h0);
        check("diff_reg_vec", 64'(busy_vec), 64'h40);

        al(5'd6); wr(5'd9, 32'h77); step(); idle();
        check("realloc_nonbusy_wr_vec", 64'(busy_vec), 64'h40);
        rd(5'd9, 5'd6); step(); idle();
        check("r9_data", 64'(rd_data), 64'h00000000_00000077);
        check("r9_r6_busy", 64'(rd_busy), 64'h2);

        // Asynchronous reset mid-cycle with a read in flight
        wr(5'd2, 32'hFF); step(); idle();
        rd(5'd2, 5'd2); al(5'd5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rd_data",  64'(rd_data),  64'h0);
        check("async_rd_busy",  64'(rd_busy),  64'h0);
        check("async_rd_valid", 64'(rd_valid), 64'h0);
        check("async_busy_vec", 64'(busy_vec), 64'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        step();
        check("post_rst_valid", 64'(rd_valid), 64'h0);

        rd(5'd2, 5'd0); step(); idle();
        check("post_rst_r2", 64'(rd_data), 64'h0);

        // Requests on the very first edge after reset release
        rst = 1'b0;
        @(negedge clk);
        rd(5'd2, 5'd8); wr(5'd8, 32'h33); al(5'd10);
        rst = 1'b1;
        step(); idle();
        check("first_edge_valid", 64'(rd_valid), 64'h1);
        check("first_edge_data",  64'(rd_data),  64'h00000033_00000000);
        check("first_edge_vec",   64'(busy_vec), 64'h400);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
